// File: rtl/hslp_pipe.sv
// hslp_pipe: 3-stage approximate unsigned multiplier with per-quadrant modes (exact/truncate/zero), 3-cycle latency, full-pipeline stall on !out_ready.
// Optional HSLP_ERR_STAT_EN adds err_cnt, a saturating count of delivered results that differ from the exact product.
module hslp_pipe #(
  parameter int W     = 8,
  parameter int TRUNC = W/4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           cfg_we,
  input  logic [7:0]     cfg_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] prod,
  output logic           busy
`ifdef HSLP_ERR_STAT_EN
  ,
  output logic [15:0]    err_cnt
`endif
);

  localparam int H = W/2;
  localparam logic [W:0]   ONE      = (W+1)'(1);
  localparam logic [W:0]   LOW_ONES = (ONE << TRUNC) - ONE;
  localparam logic [W-1:0] TMASK    = ~LOW_ONES[W-1:0];

  function automatic logic [W-1:0] apply_mode(input logic [W-1:0] q, input logic [1:0] m);
    case (m)
      2'b01:   apply_mode = q & TMASK;
      2'b10:   apply_mode = '0;
      default: apply_mode = q;
    endcase
  endfunction

  logic [7:0]     r_mode;
  logic           r1_vld, r2_vld, r3_vld;
  logic [W-1:0]   r1_a, r1_b;
  logic [7:0]     r1_mode;
  logic [W-1:0]   r2_hh, r2_hl, r2_lh, r2_ll;
  logic [2*W-1:0] r3_prod;

  logic           w_adv;
  logic [H-1:0]   w_ah, w_al, w_bh, w_bl;
  logic [W-1:0]   w_hh, w_hl, w_lh, w_ll;
  logic [2*W-1:0] w_sum;

  // Single global enable: the whole pipe freezes while the output is blocked.
  assign w_adv     = !(r3_vld && !out_ready);
  assign in_ready  = w_adv;
  assign busy      = r1_vld | r2_vld | r3_vld;
  assign out_valid = r3_vld;
  assign prod      = r3_prod;

  assign w_ah = r1_a[W-1:H];
  assign w_al = r1_a[H-1:0];
  assign w_bh = r1_b[W-1:H];
  assign w_bl = r1_b[H-1:0];

  assign w_ll = apply_mode(W'(w_al) * W'(w_bl), r1_mode[1:0]);
  assign w_lh = apply_mode(W'(w_al) * W'(w_bh), r1_mode[3:2]);
  assign w_hl = apply_mode(W'(w_ah) * W'(w_bl), r1_mode[5:4]);
  assign w_hh = apply_mode(W'(w_ah) * W'(w_bh), r1_mode[7:6]);

  assign w_sum = ((2*W)'(r2_hh) << W)
               + (((2*W)'(r2_hl) + (2*W)'(r2_lh)) << H)
               + (2*W)'(r2_ll);

  // Mode changes only while the pipe is empty and nothing is being offered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= 8'h00;
    end else if (cfg_we && !busy && !in_valid) begin
      r_mode <= cfg_mode;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_vld  <= 1'b0;
      r1_a    <= '0;
      r1_b    <= '0;
      r1_mode <= 8'h00;
      r2_vld  <= 1'b0;
      r2_hh   <= '0;
      r2_hl   <= '0;
      r2_lh   <= '0;
      r2_ll   <= '0;
      r3_vld  <= 1'b0;
      r3_prod <= '0;
    end else if (w_adv) begin
      r1_vld  <= in_valid;
      if (in_valid) begin
        r1_a    <= a;
        r1_b    <= b;
        r1_mode <= r_mode;
      end
      r2_vld  <= r1_vld;
      r2_hh   <= w_hh;
      r2_hl   <= w_hl;
      r2_lh   <= w_lh;
      r2_ll   <= w_ll;
      r3_vld  <= r2_vld;
      r3_prod <= w_sum;
    end
  end

`ifdef HSLP_ERR_STAT_EN
  logic [2*W-1:0] r2_exact;
  logic           r3_err;
  logic [15:0]    r_err_cnt;

  assign err_cnt = r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2_exact <= '0;
      r3_err   <= 1'b0;
    end else if (w_adv) begin
      r2_exact <= (2*W)'(r1_a) * (2*W)'(r1_b);
      r3_err   <= (w_sum != r2_exact);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= 16'h0000;
    end else if (r3_vld && out_ready && r3_err && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_hslp_pipe.sv
// Bench for hslp_pipe (W=8, TRUNC=2): scoreboard of expected products, per-scenario tasks.
module tb_hslp_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = 8'h00;
  logic [7:0]  b = 8'h00;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_mode = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] prod;
  logic        busy;
`ifdef HSLP_ERR_STAT_EN
  logic [15:0] err_cnt;
`endif

  int          checks = 0;
  int          errors = 0;
  int          n_out  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;
  logic [15:0] last_prod = 16'h0000;
  logic [7:0]  tb_mode = 8'h00;

  always #5 clk = ~clk;

  hslp_pipe #(.W(8), .TRUNC(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cfg_we    (cfg_we),
    .cfg_mode  (cfg_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .busy      (busy)
`ifdef HSLP_ERR_STAT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  // Exact product minus what each moded quadrant throws away.
  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y, input logic [7:0] m);
    logic [15:0] r;
    logic [7:0]  q[4];
    int          sh[4];
    q[0] = 8'(x[3:0]) * 8'(y[3:0]); sh[0] = 0;
    q[1] = 8'(x[3:0]) * 8'(y[7:4]); sh[1] = 4;
    q[2] = 8'(x[7:4]) * 8'(y[3:0]); sh[2] = 4;
    q[3] = 8'(x[7:4]) * 8'(y[7:4]); sh[3] = 8;
    r = 16'(x) * 16'(y);
    for (int i = 0; i < 4; i++) begin
      case (m[2*i +: 2])
        2'b10:   r = r - (16'(q[i]) << sh[i]);
        2'b01:   r = r - (16'(q[i] & 8'h03) << sh[i]);
        default: r = r;
      endcase
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      n_out++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result prod=%h required=none", prod);
      end else begin
        mon_exp = exp_q.pop_front();
        last_prod = prod;
        if (prod !== mon_exp) begin
          errors++;
          $display("FAIL scoreboard prod=%h required=%h", prod, mon_exp);
        end
      end
    end
  end

  task automatic send(input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    in_valid = 1'b1; a = x; b = y;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_accept in_ready=%b required=1", in_ready);
    end else begin
      exp_q.push_back(model(x, y, tb_mode));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d busy=%b required pending=0 busy=0", name, exp_q.size(), busy);
    end
  endtask

  task automatic cfg(input logic [7:0] m);
    cfg_we = 1'b1; cfg_mode = m;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    tb_mode = m;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || prod !== 16'h0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state out_valid=%b prod=%h busy=%b required 0/0000/0", out_valid, prod, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready in_ready=%b required=1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    int lat = 0;
    in_valid = 1'b1; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL latency_accept in_ready=%b required=1", in_ready);
    end
    exp_q.push_back(model(8'hFF, 8'hFF, tb_mode));
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (out_valid === 1'b1 && lat == 0) begin
        lat = k;
        checks++;
        if (prod !== 16'hFE01) begin
          errors++;
          $display("FAIL exact_ff prod=%h required=fe01", prod);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL latency cycles=%0d required=3", lat);
    end
    drain("latency");
  endtask

  task automatic test_trunc();
    cfg(8'h01);
    send(8'h0F, 8'h0F);
    drain("trunc");
    checks++;
    if (last_prod !== 16'h00E0) begin
      errors++;
      $display("FAIL trunc_ll prod=%h required=00e0", last_prod);
    end
  endtask

  task automatic test_cfg_busy();
    cfg(8'h02);
    send(8'h13, 8'h21);
    cfg_we = 1'b1; cfg_mode = 8'h00;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL cfg_busy_flag busy=%b required=1", busy);
    end
    @(posedge clk); #1;
    cfg_we = 1'b0;
    drain("zero_first");
    send(8'h13, 8'h21);
    drain("cfg_busy");
    checks++;
    if (last_prod !== 16'h0270) begin
      errors++;
      $display("FAIL cfg_ignored prod=%h required=0270", last_prod);
    end
  endtask

  task automatic test_back_to_back();
    int start = n_out;
    cfg(8'h00);
    out_ready = 1'b0;
    send(8'h12, 8'h34);
    send(8'hA5, 8'h5A);
    send(8'h0F, 8'hF0);
    in_valid = 1'b1; a = 8'hC3; b = 8'h3C;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || prod !== exp_q[0]) begin
        errors++;
        $display("FAIL stall_hold in_ready=%b out_valid=%b prod=%h required 0/1/%h", in_ready, out_valid, prod, exp_q[0]);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(8'hC3, 8'h3C);
    for (int k = 0; k < 4; k++) send(8'(k * 37 + 11), 8'(k * 53 + 7));
    drain("back_to_back");
    checks++;
    if (n_out - start != 8) begin
      errors++;
      $display("FAIL b2b_count results=%0d required=8", n_out - start);
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    cfg(8'h02);
    send(8'h13, 8'h21);
    send(8'h44, 8'h55);
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tb_mode = 8'h00;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_discard out_valid_cycles=%0d required=0", bad);
    end
    @(posedge clk); #1;
    send(8'h13, 8'h21);
    drain("reset_mid");
    checks++;
    if (last_prod !== 16'h0273) begin
      errors++;
      $display("FAIL reset_mode prod=%h required=0273", last_prod);
    end
  endtask

`ifdef HSLP_ERR_STAT_EN
  task automatic test_err_stat();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tb_mode = 8'h00;
    checks++;
    if (err_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL err_reset err_cnt=%0d required=0", err_cnt);
    end
    cfg(8'h02);
    send(8'h13, 8'h21);
    send(8'h13, 8'h21);
    send(8'h10, 8'h10);
    drain("err_stat");
    checks++;
    if (err_cnt !== 16'd2) begin
      errors++;
      $display("FAIL err_cnt err_cnt=%0d required=2", err_cnt);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_trunc();
    test_cfg_busy();
    test_back_to_back();
    test_reset_mid();
`ifdef HSLP_ERR_STAT_EN
    test_err_stat();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
